clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning divider counter width.
REQ-002 The block SHALL have parameter BURST_W, default 16, meaning burst-length width.
REQ-003 The block SHALL have parameter DEF_DIV, default 50_000_000, meaning the half-period divide value used after reset (1 Hz from 100 MHz).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: a configuration word is offered.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: the block accepts configuration.
REQ-008 The block SHALL have port cfg_div, input, CNT_W bits: half-period length in clk cycles.
REQ-009 The block SHALL have port cfg_burst, input, BURST_W bits: number of output periods; 0 means continuous.
REQ-010 The block SHALL have port start, input, 1 bit: a run request.
REQ-011 The block SHALL have port stop, input, 1 bit: an abort request.
REQ-012 The block SHALL have port op, output, 1 bit: divided square wave.
REQ-013 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each op rising edge.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-017 cfg_ready SHALL be 1 only in IDLE; cfg_valid&&cfg_ready SHALL latch div_r<=cfg_div and burst_r<=cfg_burst on that edge.
REQ-018 A latched cfg_div of 0 SHALL be stored as 1 (clamp); there is no upper clamp.
REQ-019 In IDLE, start=1 with stop=0 SHALL move to RUN next edge with cnt=0, op=0 and period count=0.
REQ-020 If cfg handshake and start occur in the same IDLE cycle, the run SHALL use the newly latched values.
REQ-021 In RUN, cnt SHALL count 0..div_r-1; at cnt==div_r-1, cnt SHALL go to 0 and op SHALL toggle.
REQ-022 The first op rise SHALL occur div_r cycles after entering RUN; the period SHALL be 2*div_r cycles with 50% duty.
REQ-023 tick SHALL be 1 in exactly the cycles where op has just changed 0->1.
REQ-024 On each op 1->0 transition the period count SHALL increment; if burst_r!=0 and the new count equals burst_r, the FSM SHALL go to DONE instead of continuing.
REQ-025 DONE SHALL last exactly one cycle with done=1, op=0, busy=0, then return to IDLE.
REQ-026 stop=1 in RUN SHALL go to IDLE next edge with op=0, cnt=0, no tick and no done; stop SHALL take priority over a coincident burst end.
REQ-027 start=1 and stop=1 together in IDLE SHALL leave the FSM in IDLE; start in RUN or DONE SHALL be ignored.
REQ-028 The period counter SHALL be BURST_W bits and SHALL NOT wrap-compare in continuous mode; it MAY wrap silently.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, cnt=0, op=0, tick=0, done=0, busy=0, div_r=DEF_DIV, burst_r=0 and cfg_ready=0 during reset.
REQ-030 cfg_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-RUN SHALL abort immediately with no done pulse.

Structure
REQ-032 Package clk_div_ctrl_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default CNT_W, BURST_W and DEF_DIV constants.
REQ-033 The half-period counter plus op toggle SHALL be one sub-module, div_counter (enable, clear, div in; op, tick out); the FSM and burst counting SHALL stay in clk_div_ctrl.

Verification
REQ-034 The bench SHALL check reset: with rst_n low for 2 cycles, outputs are 0, cfg_ready=0, and cfg_ready=1 on the first edge after release.
REQ-035 The bench SHALL check continuous mode: cfg_div=20, cfg_burst=0, start -> first tick 20 cycles after RUN, ticks every 40 cycles, and op high 20 / low 20 for at least 1000 ns.
REQ-036 The bench SHALL check burst mode: cfg_div=5, cfg_burst=3 -> exactly 3 ticks, done pulses 1 cycle 30 cycles after RUN entry, then IDLE with cfg_ready=1.
REQ-037 The bench SHALL check abort: stop 7 cycles into a cfg_div=20 run -> op=0 and busy=0 next cycle, no done, and a later start restarts from cnt=0.
REQ-038 The bench SHALL check the clamp: cfg_div=0, cfg_burst=2 -> op toggles every cycle, ticks every 2 cycles, done after 4 cycles.
REQ-039 The bench SHALL check priority and ignore rules: start+stop together in IDLE -> stays IDLE; cfg_valid during RUN -> cfg_ready=0 and div_r unchanged.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and default sizing for the clock divider controller.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEF_CNT_W   = 32;
  localparam int unsigned DEF_BURST_W = 16;
  localparam int unsigned DEF_DIV_VAL = 50_000_000;

endpackage

// File: rtl/div_counter.sv
// Half-period counter with square-wave toggle and rising-edge tick.
module div_counter
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] div,
  output logic             op,
  output logic             tick,
  output logic             half_end
);

  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last     = (cnt == div - CNT_W'(1));
  // Combinational look-ahead: op toggles on this edge.
  assign half_end = enable && !clear && last;

  // Count 0..div-1, toggle op at the terminal count; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op   <= 1'b0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      op   <= 1'b0;
      tick <= 1'b0;
    end else if (enable) begin
      if (last) begin
        cnt  <= '0;
        op   <= ~op;
        tick <= ~op;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with burst/continuous run control.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned BURST_W = DEF_BURST_W,
  parameter int unsigned DEF_DIV = DEF_DIV_VAL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               op,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   div_r;
  logic [BURST_W-1:0] burst_r;
  logic [BURST_W-1:0] per_cnt;
  logic               cnt_en;
  logic               cnt_clr;
  logic               half_end;
  logic               op_fall;
  logic               burst_end;

  // Counter runs only in RUN without abort; everything else holds it cleared,
  // which also gives cnt=0/op=0 on the edge that enters RUN.
  assign cnt_en    = (state == RUN) && !stop;
  assign cnt_clr   = !cnt_en;
  assign op_fall   = half_end && op;
  assign burst_end = op_fall && (burst_r != '0) && ((per_cnt + BURST_W'(1)) == burst_r);

  div_counter #(
    .CNT_W (CNT_W)
  ) u_div_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (cnt_en),
    .clear    (cnt_clr),
    .div      (div_r),
    .op       (op),
    .tick     (tick),
    .half_end (half_end)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; stop beats a coincident burst end.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !stop) state_nxt = RUN;
      RUN: begin
        if (stop)           state_nxt = IDLE;
        else if (burst_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration latch with zero-divide clamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r   <= CNT_W'(DEF_DIV);
      burst_r <= '0;
    end else if (cfg_valid && cfg_ready) begin
      div_r   <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
      burst_r <= cfg_burst;
    end
  end

  // Completed-period counter; wraps silently in continuous mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            per_cnt <= '0;
    else if (state != RUN) per_cnt <= '0;
    else if (op_fall)      per_cnt <= per_cnt + BURST_W'(1);
  end

  // Status outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt == RUN);
      done      <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl against an arithmetic timing model.
module tb_clk_div_ctrl;

  localparam int unsigned CW = 32;
  localparam int unsigned BW = 16;
  localparam int unsigned DDIV = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_div = '0;
  logic [BW-1:0] cfg_burst = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          op, tick, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W   (CW),
    .BURST_W (BW),
    .DEF_DIV (DDIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .op        (op),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [4:0] outs_now();
    return {cfg_ready, busy, done, op, tick};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {cfg_ready,busy,done,op,tick} k cycles after the RUN-entry edge.
  function automatic logic [4:0] model_outs(input int k, input int d, input int b);
    int  endk;
    logic o, t;
    endk = (b == 0) ? 32'h7fff_ffff : 2 * d * b;
    if (k < endk) begin
      o = ((k / d) % 2) == 1;
      t = (k % (2 * d)) == d;
      return {1'b0, 1'b1, 1'b0, o, t};
    end
    if (k == endk) return 5'b00100;
    return 5'b10000;
  endfunction

  // mode 0: cfg then start, 1: cfg with start, 2: no cfg (reset defaults).
  // stop_k < 0 means no abort; otherwise stop lands on the edge at k=stop_k.
  task automatic do_run(input int dv, input int bv, input int stop_k, input int mode);
    int d, endk;
    d    = (dv == 0) ? 1 : dv;
    endk = (bv == 0) ? -1 : 2 * d * bv;
    check_eq("idle_rdy", 32'(outs_now()), 32'h10);
    if (mode == 0) begin
      cfg_valid = 1'b1;
      cfg_div   = CW'(dv);
      cfg_burst = BW'(bv);
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_div   = CW'($urandom_range(1, 50));
      cfg_burst = BW'($urandom_range(0, 9));
    end else if (mode == 1) begin
      cfg_valid = 1'b1;
      cfg_div   = CW'(dv);
      cfg_burst = BW'(bv);
    end else begin
      cfg_valid = 1'b0;
    end
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cfg_valid = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (stop_k >= 0 && k == stop_k) begin
        check_eq($sformatf("stop_d%0d_k%0d", d, k), 32'(outs_now()), 32'h10);
        break;
      end
      check_eq($sformatf("run_d%0d_b%0d_k%0d", d, bv, k), 32'(outs_now()),
               32'(model_outs(k, d, bv)));
      if (endk >= 0 && k == endk + 1) break;
      stop      = (k + 1 == stop_k);
      start     = 1'($urandom_range(0, 1));
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_div   = CW'($urandom_range(1, 60));
      cfg_burst = BW'($urandom_range(0, 9));
      @(negedge clk);
    end
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int dv, bv, d, sk;

    // Reset held for two cycles, then release.
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async", 32'(outs_now()), 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold", 32'(outs_now()), 32'h0);
    end
    rst_n = 1'b1;
    #1 check_eq("rst_rel_rdy", 32'(cfg_ready), 32'h0);
    @(negedge clk);
    check_eq("rst_first_edge", 32'(outs_now()), 32'h10);

    // Reset defaults: DEF_DIV, continuous.
    do_run(DDIV, 0, 40, 2);

    // Continuous mode, div 20, well past 1000 ns.
    do_run(20, 0, 200, 0);

    // Burst mode, div 5, 3 periods.
    do_run(5, 3, -1, 0);

    // Abort 7 cycles in, then restart cleanly.
    do_run(20, 0, 7, 1);
    do_run(20, 0, 60, 0);

    // Zero-divide clamp with a 2-period burst.
    do_run(0, 2, -1, 1);

    // Stop coincident with burst end: abort wins, no done.
    do_run(3, 2, 12, 0);

    // start+stop together in IDLE stays idle.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    check_eq("ss_idle0", 32'(outs_now()), 32'h10);
    @(negedge clk);
    check_eq("ss_idle1", 32'(outs_now()), 32'h10);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);

    // Randomized runs.
    for (int i = 0; i < 15; i++) begin
      dv = $urandom_range(0, 6);
      bv = $urandom_range(0, 4);
      d  = (dv == 0) ? 1 : dv;
      if (bv == 0) sk = $urandom_range(1, 8 * d);
      else if ($urandom_range(0, 3) == 0) sk = $urandom_range(1, 2 * d * bv);
      else sk = -1;
      do_run(dv, bv, sk, $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset mid-run: immediate abort, no done pulse.
    cfg_valid = 1'b1;
    cfg_div   = 3;
    cfg_burst = 1;
    start     = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start     = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check_eq("rst_mid", 32'(outs_now()), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_mid_hold", 32'(outs_now()), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_rel", 32'(outs_now()), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
